approx_mult_pipe: RTL

Parametrised, pipelined unsigned multiplier built from 4x4 tiles with four run-time selectable arithmetic modes: exact, approximate tiles, OR-compressed tile combination, or both. It computes the exact product in parallel and flags, per result, whether the selected mode deviated from it. A saturating mismatch counter supports error characterisation. It sits between an operand source and a result sink on valid/ready streams, replacing fixed combinational approximate multipliers in the datapath.

---
 rtl/approx_mult_pipe.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/approx_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : approx_mult_pipe
// Description : Three-stage pipelined unsigned multiplier built from 4x4
//               tiles. Run-time modes select approximate tiles and/or
//               carry-free OR combination. The exact product is computed
//               alongside so each result can be flagged as deviating. A
//               saturating counter tracks delivered mismatches.
// Revision    : 1.0 - initial release
// ============================================================================
module approx_mult_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y,
  output logic [2*WIDTH-1:0] y_exact,
  output logic               y_err,
  input  logic               clr_err,
  output logic [CNT_W-1:0]   err_cnt
);

  localparam int T  = WIDTH / 4;
  localparam int NT = T * T;
  localparam int PW = 2 * WIDTH;

  // 2x2 block: exact except 3x3, which is approximated as 7 (fits 3 bits)
  function automatic logic [3:0] mul2x2(input logic [1:0] x, input logic [1:0] z);
    logic [3:0] r;
    r = {2'b00, x} * {2'b00, z};
    if (x == 2'b11 && z == 2'b11) r = 4'd7;
    return r;
  endfunction

  // Approximate 4x4 tile: four 2x2 blocks recombined exactly (max 175)
  function automatic logic [7:0] approx_tile(input logic [3:0] x, input logic [3:0] z);
    logic [7:0] ll, lh, hl, hh;
    ll = {4'b0000, mul2x2(x[1:0], z[1:0])};
    lh = {4'b0000, mul2x2(x[1:0], z[3:2])};
    hl = {4'b0000, mul2x2(x[3:2], z[1:0])};
    hh = {4'b0000, mul2x2(x[3:2], z[3:2])};
    return ll + (lh << 2) + (hl << 2) + (hh << 4);
  endfunction

  logic stall;

  // Stage 1 registers
  logic             v1;
  logic [WIDTH-1:0] a1, b1;
  logic [1:0]       mode1;

  // Stage 2 registers: exact tiles feed y_exact, selected tiles feed y
  logic                v2;
  logic                comb_or2;
  logic [NT-1:0][7:0]  ex_t, sel_t;

  // Tile products computed from stage 1
  logic [NT-1:0][7:0]  ex_w, sel_w;

  // Final combination computed from stage 2
  logic [PW-1:0] sum_sel, or_sel, sum_ex, y_next;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  for (genvar i = 0; i < T; i++) begin : g_row
    for (genvar j = 0; j < T; j++) begin : g_col
      assign ex_w[i*T+j]  = {4'b0000, a1[4*i +: 4]} * {4'b0000, b1[4*j +: 4]};
      assign sel_w[i*T+j] = mode1[0] ? approx_tile(a1[4*i +: 4], b1[4*j +: 4])
                                     : ex_w[i*T+j];
    end
  end

  // Weighted sum / OR of the stage-2 tiles, plus the exact reference sum
  always_comb begin
    sum_sel = '0;
    or_sel  = '0;
    sum_ex  = '0;
    for (int i = 0; i < T; i++) begin
      for (int j = 0; j < T; j++) begin
        sum_sel = sum_sel + (PW'(sel_t[i*T+j]) << (4 * (i + j)));
        or_sel  = or_sel  | (PW'(sel_t[i*T+j]) << (4 * (i + j)));
        sum_ex  = sum_ex  + (PW'(ex_t[i*T+j])  << (4 * (i + j)));
      end
    end
    y_next = comb_or2 ? or_sel : sum_sel;
  end

  // Stage 1: capture operands and mode on an input handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      a1    <= '0;
      b1    <= '0;
      mode1 <= '0;
    end else if (!stall) begin
      v1 <= in_valid;
      if (in_valid) begin
        a1    <= a;
        b1    <= b;
        mode1 <= mode;
      end
    end
  end

  // Stage 2: register all tile products and the combine mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2       <= 1'b0;
      comb_or2 <= 1'b0;
      ex_t     <= '0;
      sel_t    <= '0;
    end else if (!stall) begin
      v2 <= v1;
      if (v1) begin
        comb_or2 <= mode1[1];
        ex_t     <= ex_w;
        sel_t    <= sel_w;
      end
    end
  end

  // Stage 3: register results; held while the sink stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      y_exact   <= '0;
      y_err     <= 1'b0;
    end else if (!stall) begin
      out_valid <= v2;
      if (v2) begin
        y       <= y_next;
        y_exact <= sum_ex;
        y_err   <= (y_next != sum_ex);
      end
    end
  end

  // Mismatch counter: counts delivered mismatches, saturates, clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (clr_err) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && y_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire
